// File: rtl/div_arb_ctrl.sv
// rtl/div_arb_ctrl.sv - two-requester round-robin front end for a shared fixed-latency divider
// Optional macro DIV_ARB_ZERO_BYPASS_EN: divide-by-zero answered locally in one cycle.
module div_arb_ctrl #(
  parameter int LENGTH      = 32,
  parameter int DIV_LATENCY = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [LENGTH-1:0] r0_a,
  input  logic [LENGTH-1:0] r0_b,
  input  logic              r0_op,
  output logic              r0_rvalid,
  input  logic              r0_rready,
  output logic [LENGTH-1:0] r0_result,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [LENGTH-1:0] r1_a,
  input  logic [LENGTH-1:0] r1_b,
  input  logic              r1_op,
  output logic              r1_rvalid,
  input  logic              r1_rready,
  output logic [LENGTH-1:0] r1_result,
  output logic [LENGTH-1:0] oper_a,
  output logic [LENGTH-1:0] oper_b,
  output logic              operation,
  output logic              enable_div,
  input  logic [LENGTH-1:0] div_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q;
  logic [LENGTH-1:0] a_q, b_q, res_q;
  logic              op_q, id_q, last_q;

  logic              grant_vld, grant_id, accept, bypass, rready_sel;
  logic [LENGTH-1:0] sel_a, sel_b;
  logic              sel_op;

  // Both valid: the requester not served last wins; otherwise whoever is valid.
  assign grant_vld  = r0_valid | r1_valid;
  assign grant_id   = (r0_valid & r1_valid) ? ~last_q : r1_valid;
  assign accept     = (state_q == IDLE) & grant_vld & ~rst;
  assign sel_a      = grant_id ? r1_a : r0_a;
  assign sel_b      = grant_id ? r1_b : r0_b;
  assign sel_op     = grant_id ? r1_op : r0_op;
  assign rready_sel = id_q ? r1_rready : r0_rready;

`ifdef DIV_ARB_ZERO_BYPASS_EN
  assign bypass = accept & (sel_b == '0);
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bypass ? RESP : BUSY;
      BUSY:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rready_sel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= 1'b0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
      res_q  <= '0;
    end else begin
      if (accept) begin
        a_q    <= sel_a;
        b_q    <= sel_b;
        op_q   <= sel_op;
        id_q   <= grant_id;
        last_q <= grant_id;
        cnt_q  <= 8'(DIV_LATENCY - 1);
        if (bypass) res_q <= sel_op ? sel_a : '1;
      end else if (state_q == BUSY) begin
        if (cnt_q == '0) res_q <= div_o;
        else             cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  // Outputs are forced low while reset is asserted.
  always_comb begin
    r0_ready   = 1'b0;
    r1_ready   = 1'b0;
    r0_rvalid  = 1'b0;
    r1_rvalid  = 1'b0;
    r0_result  = '0;
    r1_result  = '0;
    oper_a     = '0;
    oper_b     = '0;
    operation  = 1'b0;
    enable_div = 1'b0;
    if (!rst) begin
      oper_a    = a_q;
      oper_b    = b_q;
      operation = op_q;
      case (state_q)
        IDLE: begin
          r0_ready = grant_vld & ~grant_id;
          r1_ready = grant_vld & grant_id;
        end
        BUSY: enable_div = 1'b1;
        RESP: begin
          r0_rvalid = ~id_q;
          r1_rvalid = id_q;
          if (id_q) r1_result = res_q;
          else      r0_result = res_q;
        end
        default: ;
      endcase
    end
  end

endmodule
